// File: rtl/multicycle_main_controller.sv
// Main control FSM for the multicycle RV32I datapath: sequences each instruction,
// drives every datapath enable and mux select, and counts retired instructions.
module multicycle_main_controller #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       op,
    input  logic [2:0]       func3,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             AdrSrc,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       AluOp,
    output logic [2:0]       ImmSrc,
    output logic             RegWrite,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10,
        LUI      = 4'd11
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             retire;

    always_comb begin
        state_d   = FETCH;
        retire    = 1'b0;
        PCWrite   = 1'b0;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        AluOp     = 2'b00;
        RegWrite  = 1'b0;
        illegal   = 1'b0;
        case (state_q)
            FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                // Reset parks the FSM in FETCH, so gating here keeps all writes off during reset
                IRWrite   = mem_ready & rst_n;
                PCWrite   = mem_ready & rst_n;
                state_d   = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LOAD, OP_STORE: state_d = MEMADR;
                    OP_RTYPE:          state_d = EXECR;
                    OP_ITYPE:          state_d = EXECI;
                    OP_BRANCH:         state_d = BRANCH;
                    OP_JAL:            state_d = JAL;
                    OP_LUI:            state_d = LUI;
                    default:           illegal = 1'b1;
                endcase
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = (op == OP_LOAD) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                AdrSrc  = 1'b1;
                state_d = mem_ready ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                retire    = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                retire   = mem_ready;
                state_d  = mem_ready ? FETCH : MEMWRITE;
            end
            EXECR: begin
                ALUSrcA = 2'b10;
                AluOp   = 2'b10;
                state_d = ALUWB;
            end
            EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                AluOp   = 2'b11;
                state_d = ALUWB;
            end
            ALUWB: begin
                RegWrite = 1'b1;
                retire   = 1'b1;
            end
            BRANCH: begin
                ALUSrcA = 2'b10;
                AluOp   = 2'b01;
                PCWrite = ((func3 == 3'b000) & zero) | ((func3 == 3'b001) & ~zero);
                retire  = 1'b1;
            end
            JAL: begin
                // PC takes the target from ALUOut while the ALU forms the link value OldPC+4
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
                state_d = ALUWB;
            end
            LUI: begin
                ALUSrcA = 2'b11;
                ALUSrcB = 2'b01;
                state_d = ALUWB;
            end
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        case (op)
            OP_STORE:  ImmSrc = 3'b001;
            OP_BRANCH: ImmSrc = 3'b010;
            OP_JAL:    ImmSrc = 3'b011;
            OP_LUI:    ImmSrc = 3'b100;
            default:   ImmSrc = 3'b000;
        endcase
    end

    assign retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
    assign retired   = retired_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

endmodule

// File: doc/multicycle_main_controller.md
# multicycle_main_controller

Main control FSM for the multicycle RV32I datapath. It sequences fetch, decode, execute, memory and writeback for each instruction and drives every datapath enable and mux select. It is the producer of the 2-bit `AluOp` class code, which the ALU controller decodes together with `func3`/`func7` into the 3-bit ALU operation. It also handles the memory ready handshake and keeps a retired-instruction counter.

## Interface
- `CNT_W`, 32, width of the retired-instruction counter
- `clk` input 1 — rising-edge clock
- `rst_n` input 1 — asynchronous, active-low reset
- `op` input 7 — opcode field of the instruction register
- `func3` input 3 — funct3 field, used for branch condition select
- `zero` input 1 — ALU zero flag, valid in the cycle the ALU computes rs1−rs2
- `mem_ready` input 1 — memory completes the current access this cycle
- `PCWrite` output 1 — PC register load
- `AdrSrc` output 1 — memory address select: 0=PC, 1=ALUOut
- `MemWrite` output 1 — data memory write request
- `IRWrite` output 1 — instruction register and OldPC load
- `ResultSrc` output 2 — result select: 00=ALUOut, 01=MemData, 10=ALU result
- `ALUSrcA` output 2 — ALU A select: 00=PC, 01=OldPC, 10=rs1, 11=zero
- `ALUSrcB` output 2 — ALU B select: 00=rs2, 01=imm, 10=constant 4
- `AluOp` output 2 — class code: 00=add, 01=branch/sub, 10=R-type, 11=I-type
- `ImmSrc` output 3 — immediate format: 000=I, 001=S, 010=B, 011=J, 100=U
- `RegWrite` output 1 — register file write enable
- `illegal` output 1 — unrecognised opcode, asserted in DECODE
- `retired` output CNT_W — count of completed instructions

## Operation
- States use a 4-bit encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, JAL=10, LUI=11. Codes 12–15 return to FETCH with all enables at 0.
- Any control output not listed for a state below is 0 in that state.
- **FETCH:** AdrSrc=0, ALUSrcA=00, ALUSrcB=10, AluOp=00, ResultSrc=10.
  - IRWrite = PCWrite = mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- **DECODE:** ALUSrcA=01, ALUSrcB=01, AluOp=00, which computes the branch/jump target into ALUOut. Next state by `op`:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 0110111 → LUI
  - any other opcode → FETCH, with illegal=1 for this one cycle
- **MEMADR:** ALUSrcA=10, ALUSrcB=01, AluOp=00. Goes to MEMREAD if op=0000011, otherwise MEMWRITE.
- **MEMREAD:** AdrSrc=1, ResultSrc=00. Holds while mem_ready=0, then goes to MEMWB.
- **MEMWB:** ResultSrc=01, RegWrite=1. Goes to FETCH.
- **MEMWRITE:** AdrSrc=1, ResultSrc=00, MemWrite=1. MemWrite stays high every cycle until mem_ready=1, then goes to FETCH.
- **EXECR:** ALUSrcA=10, ALUSrcB=00, AluOp=10. Goes to ALUWB.
- **EXECI:** ALUSrcA=10, ALUSrcB=01, AluOp=11. Goes to ALUWB.
- **ALUWB:** ResultSrc=00, RegWrite=1. Goes to FETCH.
- **BRANCH:** ALUSrcA=10, ALUSrcB=00, AluOp=01, ResultSrc=00.
  - PCWrite = (func3==000 & zero) | (func3==001 & ~zero).
  - Any other func3 is never taken.
  - Goes to FETCH.
- **JAL:** ALUSrcA=01, ALUSrcB=10, AluOp=00, ResultSrc=00, PCWrite=1. This loads the PC from the target in ALUOut while the ALU forms OldPC+4. Goes to ALUWB.
- **LUI:** ALUSrcA=11, ALUSrcB=01, AluOp=00. Goes to ALUWB.
- **ImmSrc** is combinational from `op` in every state:
  - 0100011 → S
  - 1100011 → B
  - 1101111 → J
  - 0110111 → U
  - all other opcodes → I
- **retired** increments by 1, wrapping modulo 2^CNT_W, on each clock edge that leaves MEMWB, MEMWRITE (with mem_ready=1), ALUWB or BRANCH toward FETCH. It does not increment on the illegal-opcode path or from codes 12–15.

## Timing
- **Reset (rst_n=0):** state=FETCH, retired=0, illegal=0.
  - PCWrite, IRWrite, MemWrite and RegWrite are forced to 0 regardless of mem_ready.
  - Mux selects show their FETCH values.
- **Reset mid-instruction:** the instruction is abandoned immediately, with no further writes. Execution resumes in FETCH on the first clock edge after rst_n rises.
- Outputs are Moore decodes of state, except that PCWrite and IRWrite in FETCH, PCWrite in BRANCH, and illegal depend combinationally on inputs.
- **Cycles per instruction with mem_ready held at 1:**
  - lw: 5
  - sw, R-type, I-type, jal, lui: 4
  - branch: 3
  - illegal opcode: 2
- Each cycle mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds one cycle.
- In the same clock edge, the retire increment and the return to FETCH happen together, with no extra cycle.

## Test plan
- **Reset mid-instruction:** assert rst_n=0 during EXECR → all enables 0 immediately, retired=0. After release, the first cycle is FETCH with IRWrite=1 when mem_ready=1.
- **R-type:** add (op=0110011), mem_ready=1 → AluOp sequence 00, 00, 10, then RegWrite=1 in cycle 4, retired +1.
- **lw with stalls:** lw with mem_ready=0 for 2 cycles in MEMREAD → 7 cycles total, MemData written in the MEMWB cycle (ResultSrc=01). Same stalls with sw → MemWrite high for 3 consecutive cycles.
- **Branches:** beq with zero=1 → PCWrite=1 in cycle 3. Same with zero=0 → PCWrite=0. bne with zero=0 → PCWrite=1. All three take 3 cycles.
- **jal and lui:** jal → PCWrite=1 in cycle 3 and RegWrite=1 in cycle 4, ImmSrc=011. lui → ALUSrcA=11 with ImmSrc=100.
- **Illegal opcode and counter wrap:** op=1111111 → illegal=1 in DECODE, back in FETCH next cycle, retired unchanged. With CNT_W=4, 16 retired instructions → retired wraps to 0.
